// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver FSM state encoding.
// Imported by the receiver, the transmitter and the synchronizer users.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;
  logic sync_r;

  // synchronizer flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser timed by an oversample strobe, with a
// valid/ready byte output and framing-error / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);

  logic                  rx_s;
  rx_state_t             state_r, state_s;
  logic [TW-1:0]         tick_cnt_r, tick_cnt_s;
  logic [IW-1:0]         bit_idx_r, bit_idx_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
  logic                  rx_valid_r, rx_valid_s;
  logic                  frame_err_r, frame_err_s;
  logic                  overrun_r, overrun_s;
  logic                  done_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // next-state, counters and shifter; everything advances only on a baud tick
  always_comb begin
    state_s     = state_r;
    tick_cnt_s  = tick_cnt_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    done_s      = 1'b0;
    frame_err_s = 1'b0;
    if (baud_en_i) begin
      case (state_r)
        RX_IDLE: begin
          if (!rx_s) begin
            tick_cnt_s = {TW{1'b0}};
            state_s    = RX_START;
          end else begin
            state_s = RX_IDLE;
          end
        end
        RX_START: begin
          if (tick_cnt_r == HALF_LAST) begin
            if (!rx_s) begin
              tick_cnt_s = {TW{1'b0}};
              bit_idx_s  = {IW{1'b0}};
              state_s    = RX_DATA;
            end else begin
              state_s = RX_IDLE;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + TW'(1);
          end
        end
        RX_DATA: begin
          if (tick_cnt_r == FULL_LAST) begin
            shift_s    = {rx_s, shift_r[DATA_WIDTH-1:1]};
            tick_cnt_s = {TW{1'b0}};
            if (bit_idx_r == LAST_BIT) begin
              state_s = RX_STOP;
            end else begin
              bit_idx_s = bit_idx_r + IW'(1);
            end
          end else begin
            tick_cnt_s = tick_cnt_r + TW'(1);
          end
        end
        RX_STOP: begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_cnt_s = {TW{1'b0}};
            if (rx_s) begin
              done_s  = 1'b1;
              state_s = RX_IDLE;
            end else begin
              frame_err_s = 1'b1;
              state_s     = RX_BREAK;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + TW'(1);
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            state_s = RX_IDLE;
          end else begin
            state_s = RX_BREAK;
          end
        end
        default: begin
          state_s = RX_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // byte handshake: a completion in the same cycle as a consume is not an overrun
  always_comb begin
    rx_data_s  = rx_data_r;
    rx_valid_s = rx_valid_r;
    overrun_s  = 1'b0;
    if (done_s) begin
      rx_data_s  = shift_r;
      rx_valid_s = 1'b1;
      overrun_s  = rx_valid_r & ~rx_ready_i;
    end else if (rx_valid_r && rx_ready_i) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
    end
  end

  // state, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= RX_IDLE;
      tick_cnt_r  <= {TW{1'b0}};
      bit_idx_r   <= {IW{1'b0}};
      shift_r     <= {DATA_WIDTH{1'b0}};
      rx_data_r   <= {DATA_WIDTH{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      tick_cnt_r  <= tick_cnt_s;
      bit_idx_r   <= bit_idx_s;
      shift_r     <= shift_s;
      rx_data_r   <= rx_data_s;
      rx_valid_r  <= rx_valid_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  assign rx_data_o   = rx_data_r;
  assign rx_valid_o  = rx_valid_r;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;
  assign busy_o      = (state_r != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven at the line level
// and received bytes are compared against a queue of expected bytes.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int BAUD_DIV = 2;

  logic       clk;
  logic       rst_ni;
  logic       baud_en;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // observed events, recorded by the monitor
  logic [7:0] got_q[$];
  int vhi_cnt  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  // reference model: bytes the consumer should see, in order
  logic [7:0] exp_q[$];

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .baud_en_i   (baud_en),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div     = 0;
    baud_en = 1'b0;
    forever begin
      @(negedge clk);
      div     = (div + 1) % BAUD_DIV;
      baud_en = (div == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
    if (rx_valid_o)  vhi_cnt  = vhi_cnt + 1;
    if (frame_err_o) ferr_cnt = ferr_cnt + 1;
    if (overrun_o)   ovr_cnt  = ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_en !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int v0, f0, o0;
    logic [7:0] b;
    rst_ni     = 1'b0;
    rx_i       = 1'b1;
    rx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  rx_data_o,   32'h0);
    check("rst_valid", rx_valid_o,  32'h0);
    check("rst_ferr",  frame_err_o, 32'h0);
    check("rst_ovr",   overrun_o,   32'h0);
    check("rst_busy",  busy_o,      32'h0);
    rst_ni = 1'b1;
    wait_ticks(10);

    // basic byte with ready held high
    v0 = vhi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    wait_ticks(4);
    check("a5_pulse_len", vhi_cnt - v0, 32'd1);
    check("a5_ferr", ferr_cnt - f0, 32'd0);
    check("a5_ovr", ovr_cnt - o0, 32'd0);
    drain("a5");

    // random bytes with random idle gaps
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      exp_q.push_back(b);
      wait_ticks($urandom_range(0, 20));
    end
    wait_ticks(4);
    drain("rand");

    // short low glitch while idle
    f0 = ferr_cnt;
    rx_i = 1'b0;
    wait_ticks(4);
    rx_i = 1'b1;
    wait_ticks(32);
    check("glitch_busy", busy_o, 32'h0);
    check("glitch_valid", rx_valid_o, 32'h0);
    check("glitch_ferr", ferr_cnt - f0, 32'd0);
    drain("glitch");

    // framing error, held-low break, then a good byte
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_ticks(3 * OS);
    check("break_busy", busy_o, 32'h1);
    check("break_ferr", ferr_cnt - f0, 32'd1);
    check("break_valid", rx_valid_o, 32'h0);
    rx_i = 1'b1;
    wait_ticks(OS);
    check("break_exit", busy_o, 32'h0);
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    wait_ticks(4);
    check("break_ferr_total", ferr_cnt - f0, 32'd1);
    drain("break");

    // overrun: older unconsumed byte is lost
    o0 = ovr_cnt;
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_ticks(4);
    check("ovr_first_ovr", ovr_cnt - o0, 32'd0);
    send_frame(8'h22, 1'b1);
    wait_ticks(4);
    check("ovr_valid", rx_valid_o, 32'h1);
    check("ovr_data", rx_data_o, 32'h22);
    check("ovr_pulse", ovr_cnt - o0, 32'd1);
    rx_ready_i = 1'b1;
    exp_q.push_back(8'h22);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("ovr_consumed", rx_valid_o, 32'h0);
    drain("ovr");

    // async reset in the middle of bit 4 of 0xFF
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_i = 1'b1;
    wait_ticks(5);
    #3 rst_ni = 1'b0;
    #1;
    check("mid_rst_data", rx_data_o, 32'h0);
    check("mid_rst_valid", rx_valid_o, 32'h0);
    check("mid_rst_busy", busy_o, 32'h0);
    repeat (4) @(posedge clk);
    #1 rst_ni = 1'b1;
    wait_ticks(20);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    wait_ticks(4);
    check("mid_rst_ferr", ferr_cnt - f0, 32'd0);
    check("mid_rst_ovr", ovr_cnt - o0, 32'd0);
    drain("mid_rst");

    // back-to-back frames with no idle gap
    v0 = vhi_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    wait_ticks(4);
    check("b2b_pulses", vhi_cnt - v0, 32'd3);
    check("b2b_ovr", ovr_cnt - o0, 32'd0);
    drain("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous serial line into bytes, timed by the 16× oversample strobe from the baud generator. It sits between the FPGA pin and the user-side byte interface, forming the receive half of the UART. Output is a valid/ready byte handshake with framing-error and overrun flags.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, sent LSB first; 8N1 format, no parity.
- `OVERSAMPLE`, 16: baud strobes per bit period. Must be even and ≥ 8.
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `baud_en_i`  in  1  one-cycle strobe at OVERSAMPLE × baud rate, synchronous to `clk_i`.
- `rx_i`  in  1  raw serial line; asynchronous, idles high.
- `rx_data_o`  out  DATA_WIDTH  last received byte.
- `rx_valid_o`  out  1  `rx_data_o` holds an unconsumed byte.
- `rx_ready_i`  in  1  consumer accepts the byte.
- `frame_err_o`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun_o`  out  1  one-cycle pulse when a byte completes while `rx_valid_o` = 1.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All FSM decisions use `rx_s`, and only in cycles where `baud_en_i` = 1.
- Counters:
  - `tick_cnt`, width $clog2(OVERSAMPLE).
  - `bit_idx`, width $clog2(DATA_WIDTH).
  - `shift_r`, DATA_WIDTH bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a tick with `rx_s` = 0, clear `tick_cnt` and go to START.
- START: increment `tick_cnt` on each tick. At `tick_cnt` = OVERSAMPLE/2−1 (mid start bit):
  - `rx_s` = 0: clear `tick_cnt`, clear `bit_idx`, go to DATA.
  - `rx_s` = 1: treat as a glitch and return to IDLE. No flags.
- DATA: on each tick, at `tick_cnt` = OVERSAMPLE−1, shift right with `shift_r[MSB]` ← `rx_s` and clear `tick_cnt`; otherwise increment `tick_cnt`.
  - After the shift with `bit_idx` = DATA_WIDTH−1, go to STOP; otherwise increment `bit_idx`.
- STOP: at `tick_cnt` = OVERSAMPLE−1 (mid stop bit):
  - `rx_s` = 1: load `rx_data_o` ← `shift_r`, set `rx_valid_o`, go to IDLE.
  - `rx_s` = 0: pulse `frame_err_o`, discard the byte, leave `rx_valid_o` unchanged, go to BREAK.
- BREAK: stay until a tick with `rx_s` = 1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Handshake:
  - `rx_valid_o` clears on the cycle after `rx_valid_o` & `rx_ready_i`.
  - If a new byte completes while `rx_valid_o` = 1, the new byte overwrites `rx_data_o`, `rx_valid_o` stays 1, and `overrun_o` pulses.
  - If completion coincides with `rx_ready_i` = 1 and `rx_valid_o` = 1, the old byte counts as consumed: `rx_valid_o` stays 1 with the new data and there is no overrun.
- `baud_en_i` may pulse irregularly, e.g. when the baud select changes. The FSM simply counts strobes and does not detect rate changes.

## Timing
- Reset values:
  - `rx_data_o` = 0, `rx_valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0.
  - State = IDLE; all counters and `shift_r` = 0.
- Reset asserted mid-frame aborts immediately. The partial byte is lost and no flag pulses.
- All outputs are registered; `busy_o` decodes directly from the state register.
- Start-detect latency is 2 clocks of synchronizer plus up to 1 tick of IDLE polling.
- Sampling points are at ticks OVERSAMPLE/2 + k·OVERSAMPLE after the start edge (k = 1..DATA_WIDTH+1), i.e. mid-bit.
- `rx_valid_o` and `frame_err_o` assert in the clock after the mid-stop-bit tick. Total latency is ≈ 9.5 bit periods from the falling start edge.
- `rx_valid_o` can rise again 1 clock after it falls; there is no dead cycle.

## Structure
- Package `uart_pkg` holds the FSM state enum `rx_state_t`, `UART_OVERSAMPLE` = 16 and `UART_DATA_WIDTH` = 8. The transmitter shares these.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with an async active-low reset value parameter. It is reused for other async inputs.

## Test plan
- Byte 0xA5, 16 strobes/bit, `rx_ready_i` = 1 → `rx_valid_o` 1-cycle pulse with `rx_data_o` = 0xA5; no `frame_err_o`/`overrun_o`.
- 4-strobe low glitch on `rx_i` while idle → FSM returns to IDLE; `rx_valid_o` and `frame_err_o` stay 0.
- Byte 0x3C with stop bit driven low, then line held low 3 bit periods, then high, then byte 0x5A → one `frame_err_o` pulse, BREAK until high, then `rx_data_o` = 0x5A valid.
- `rx_ready_i` = 0, send 0x11 then 0x22 → after the second byte `rx_data_o` = 0x22, `rx_valid_o` = 1, one `overrun_o` pulse.
- Async `rst_ni` low during bit 4 of 0xFF, release, send 0x81 → outputs at reset values while low; 0x81 then received correctly.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, `rx_ready_i` = 1 → three valid pulses in order with matching data.
